serial_frame_rx: RTL

//  Parametrised serial frame receiver, one bit per clk, no oversampling: start(0), DATA_W data bits LSB first,

---
 rtl/serial_rx_pkg.sv | 38 +++
 rtl/serial_rx_hold.sv | 65 ++++++
 rtl/serial_frame_rx.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_pkg.sv
// -----------------------------------------------------------------------------
// serial_rx_pkg
//   Shared types and constants for the serial frame receiver.
//   - rx_state_e : receiver FSM state encoding (3-bit, fixed values so the
//                  encoding stays stable across tools and legacy dumps)
//   - PAR_*      : values for the PARITY_MODE parameter
//   - parity_bad : parity check over the XOR of the data bits plus the
//                  received parity bit
// -----------------------------------------------------------------------------
package serial_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DATA      = 3'd1,
    PARITY    = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // data_xor is the reduction XOR of the received data bits. Even parity
  // wants an even number of ones across data+parity, odd wants an odd number.
  function automatic logic parity_bad(input int mode, input logic data_xor,
                                      input logic par_bit);
    logic ones_odd;
    ones_odd = data_xor ^ par_bit;
    if (mode == PAR_EVEN) begin
      return ones_odd;
    end else if (mode == PAR_ODD) begin
      return ~ones_odd;
    end
    return 1'b0;
  endfunction

endpackage

// File: rtl/serial_rx_hold.sv
// -----------------------------------------------------------------------------
// serial_rx_hold
//   One-entry valid/ready holding register for received words.
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     in_valid    : 1-cycle strobe, a good word has just completed
//     in_data     : the completed word
//     out_data    : held word, stable while out_valid & !out_ready
//     out_valid   : holding register full
//     out_ready   : consumer accepts (transfer = out_valid & out_ready)
//     overrun     : 1-cycle pulse, a completed word was dropped because the
//                   register was full and not being drained in that cycle
// -----------------------------------------------------------------------------
module serial_rx_hold #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overrun
);

  logic [DATA_W-1:0] data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              overrun_reg, overrun_next;

  always_comb begin
    data_next    = data_reg;
    valid_next   = valid_reg;
    overrun_next = 1'b0;
    if (in_valid) begin
      if (valid_reg && !out_ready) begin
        // Keep the unread word; the newcomer is lost.
        overrun_next = 1'b1;
      end else begin
        // Empty, or the old word leaves in this same cycle: load and stay full.
        data_next  = in_data;
        valid_next = 1'b1;
      end
    end else if (valid_reg && out_ready) begin
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      overrun_reg <= overrun_next;
    end
  end

  assign out_data  = data_reg;
  assign out_valid = valid_reg;
  assign overrun   = overrun_reg;

endmodule

// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//   Serial frame receiver, one line sample per clk (no oversampling).
//   Frame: start(0), DATA_W data bits LSB first, optional parity bit,
//   STOP_BITS stop(1) bits. Good words go out through serial_rx_hold.
//   Parameters:
//     DATA_W      data bits per frame (5..16)
//     PARITY_MODE PAR_NONE / PAR_EVEN / PAR_ODD
//     STOP_BITS   stop bits checked (1..2)
//     ERR_CNT_W   width of err_count
//   Ports:
//     clk, reset  : clock, synchronous active-high reset
//     din         : serial line, idle high
//     out_data    : received word, valid while out_valid
//     out_valid   : holding register full
//     out_ready   : consumer accepts
//     frame_err   : 1-cycle pulse, a stop bit was sampled 0
//     parity_err  : 1-cycle pulse, parity mismatch with good stop bits
//     overrun     : 1-cycle pulse, good word lost (holding register full)
//     err_count   : saturating error count, only when the macro
//                   SERIAL_RX_ERR_CNT_EN is defined
// -----------------------------------------------------------------------------
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int ERR_CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 din,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
`ifdef SERIAL_RX_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_count
`endif
);

  localparam int CNT_W = $clog2(DATA_W);

  // Range guard: an illegal configuration elaborates this empty scope, which
  // makes it easy to spot in the hierarchy.
  localparam bit CFG_OK = (DATA_W >= 5) && (DATA_W <= 16) &&
                          (STOP_BITS >= 1) && (STOP_BITS <= 2) &&
                          (PARITY_MODE >= PAR_NONE) && (PARITY_MODE <= PAR_ODD) &&
                          (ERR_CNT_W >= 1);
  if (!CFG_OK) begin : g_cfg_illegal
  end

  rx_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  bit_cnt_reg, bit_cnt_next;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic              par_bad_reg, par_bad_next;
  logic              stop_cnt_reg, stop_cnt_next;
  logic              frame_err_reg, frame_err_next;
  logic              parity_err_reg, parity_err_next;
  logic              deliver;
  logic              stop_last;

  // With one stop bit the counter never leaves 0, so this is always true.
  assign stop_last = (stop_cnt_reg == 1'(STOP_BITS - 1));

  always_comb begin
    state_next      = state_reg;
    bit_cnt_next    = bit_cnt_reg;
    shift_next      = shift_reg;
    par_bad_next    = par_bad_reg;
    stop_cnt_next   = stop_cnt_reg;
    frame_err_next  = 1'b0;
    parity_err_next = 1'b0;
    deliver         = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!din) begin
          state_next    = DATA;
          bit_cnt_next  = '0;
          par_bad_next  = 1'b0;
          stop_cnt_next = 1'b0;
        end
      end

      DATA: begin
        // Shifting in from the top leaves the first (LSB) bit at bit 0
        // once all DATA_W samples are in.
        shift_next   = {din, shift_reg[DATA_W-1:1]};
        bit_cnt_next = bit_cnt_reg + 1'b1;
        if (bit_cnt_reg == CNT_W'(DATA_W - 1)) begin
          state_next = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
        end
      end

      PARITY: begin
        par_bad_next = parity_bad(PARITY_MODE, ^shift_reg, din);
        state_next   = STOP;
      end

      STOP: begin
        if (!din) begin
          // Framing error wins over any pending parity error.
          frame_err_next = 1'b1;
          state_next     = WAIT_IDLE;
        end else if (!stop_last) begin
          stop_cnt_next = stop_cnt_reg + 1'b1;
        end else begin
          if (par_bad_reg) begin
            parity_err_next = 1'b1;
          end else begin
            deliver = 1'b1;
          end
          // Straight to IDLE so a start bit in the very next cycle is taken.
          state_next = IDLE;
        end
      end

      WAIT_IDLE: begin
        // A low line after a framing error is not a start bit.
        if (din) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      par_bad_reg    <= 1'b0;
      stop_cnt_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
      parity_err_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      bit_cnt_reg    <= bit_cnt_next;
      shift_reg      <= shift_next;
      par_bad_reg    <= par_bad_next;
      stop_cnt_reg   <= stop_cnt_next;
      frame_err_reg  <= frame_err_next;
      parity_err_reg <= parity_err_next;
    end
  end

  serial_rx_hold #(
    .DATA_W(DATA_W)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .in_valid (deliver),
    .in_data  (shift_reg),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .overrun  (overrun)
  );

  assign frame_err  = frame_err_reg;
  assign parity_err = parity_err_reg;

`ifdef SERIAL_RX_ERR_CNT_EN
  // Counts the registered pulses, so the count moves one cycle after a pulse.
  logic [ERR_CNT_W-1:0] err_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_count_reg <= '0;
    end else if ((frame_err_reg || parity_err_reg || overrun) &&
                 (err_count_reg != '1)) begin
      err_count_reg <= err_count_reg + 1'b1;
    end
  end

  assign err_count = err_count_reg;
`endif

endmodule
